// File: rtl/axi_lite_cmd_pkg.sv
// axi_lite_cmd_pkg: shared state encoding, response codes and command record for the AXI-Lite command player.
package axi_lite_cmd_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // Widest supported bus; the player keeps only its own ADDR_W/DATA_W low bits meaningful.
  localparam int CMD_ADDR_W = 64;
  localparam int CMD_DATA_W = 64;
  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;
  function automatic logic is_busy(input state_e s);
    return s inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
  endfunction
endpackage

// File: rtl/axi_lite_cmd_timer.sv
// axi_lite_cmd_timer: saturating handshake-stall counter; expired marks the LIMIT-th enabled cycle (LIMIT=0 never expires).
module axi_lite_cmd_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = LIMIT < 2 ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX  = W'(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT == 0 ? 0 : LIMIT - 1);
  logic [W-1:0] count_q, count_d;
  always_comb begin
    count_d = clr ? '0 : (en && count_q != MAX) ? count_q + 1'b1 : count_q;
    expired = (LIMIT != 0) && en && count_q >= LAST;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else     count_q <= count_d;
endmodule

// File: rtl/axi_lite_cmd_player.sv
// axi_lite_cmd_player: replays write / read-check commands as single AXI-Lite transactions with per-command result.
// Define CMD_PLAYER_STATS_EN to add saturating completed/error command counters.
import axi_lite_cmd_pkg::*;
module axi_lite_cmd_player #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                rsp_mismatch,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_valid,
  input  logic                w_ready,
  input  logic [1:0]          b_resp,
  input  logic                b_valid,
  output logic                b_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic                ar_valid,
  input  logic                ar_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_valid,
  output logic                r_ready
`ifdef CMD_PLAYER_STATS_EN
  ,
  output logic [15:0]         stat_cmd_count,
  output logic [15:0]         stat_err_count
`endif
);
  state_e state_q, state_d;
  cmd_t cmd_q, cmd_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_resp_q, rsp_resp_d;
  logic rsp_mismatch_q, rsp_mismatch_d, rsp_timeout_q, rsp_timeout_d;
  logic live_q, tmr_expired, tmo_fire, cmd_unused;
  axi_lite_cmd_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .clr(state_q == IDLE), .en(is_busy(state_q)), .expired(tmr_expired)
  );
  // live_q keeps cmd_ready low while reset is asserted and for the first cycle after
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      rsp_data_q     <= '0;
      rsp_resp_q     <= RESP_OKAY;
      rsp_mismatch_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      live_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      rsp_data_q     <= rsp_data_d;
      rsp_resp_q     <= rsp_resp_d;
      rsp_mismatch_q <= rsp_mismatch_d;
      rsp_timeout_q  <= rsp_timeout_d;
      live_q         <= 1'b1;
    end
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    aw_done_d      = aw_done_q | (aw_valid & aw_ready);
    w_done_d       = w_done_q | (w_valid & w_ready);
    rsp_data_d     = rsp_data_q;
    rsp_resp_d     = rsp_resp_q;
    rsp_mismatch_d = rsp_mismatch_q;
    rsp_timeout_d  = rsp_timeout_q;
    tmo_fire       = 1'b0;
    case (state_q)
      IDLE: if (cmd_ready && cmd_valid) begin
        cmd_d     = '{write: cmd_write, addr: CMD_ADDR_W'(cmd_addr), data: CMD_DATA_W'(cmd_data)};
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: if (aw_done_d && w_done_d) state_d = WR_RESP;
              else tmo_fire = tmr_expired;
      WR_RESP: if (b_valid) begin
        state_d        = RSP;
        rsp_data_d     = '0;
        rsp_resp_d     = b_resp;
        rsp_mismatch_d = 1'b0;
        rsp_timeout_d  = 1'b0;
      end else tmo_fire = tmr_expired;
      RD_REQ: if (ar_ready) state_d = RD_RESP;
              else tmo_fire = tmr_expired;
      RD_RESP: if (r_valid) begin
        state_d        = RSP;
        rsp_data_d     = r_data;
        rsp_resp_d     = r_resp;
        rsp_mismatch_d = r_data != cmd_q.data[DATA_W-1:0];
        rsp_timeout_d  = 1'b0;
      end else tmo_fire = tmr_expired;
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_fire) begin
      state_d        = RSP;
      rsp_data_d     = '0;
      rsp_resp_d     = RESP_SLVERR;
      rsp_mismatch_d = 1'b0;
      rsp_timeout_d  = 1'b1;
    end
  end
  always_comb begin
    cmd_ready    = live_q && state_q == IDLE;
    aw_valid     = state_q == WR_REQ && !aw_done_q;
    w_valid      = state_q == WR_REQ && !w_done_q;
    b_ready      = state_q == WR_RESP;
    ar_valid     = state_q == RD_REQ;
    r_ready      = state_q == RD_RESP;
    rsp_valid    = state_q == RSP;
    aw_addr      = cmd_q.addr[ADDR_W-1:0];
    ar_addr      = cmd_q.addr[ADDR_W-1:0];
    w_data       = cmd_q.data[DATA_W-1:0];
    w_strb       = '1;
    rsp_data     = rsp_data_q;
    rsp_resp     = rsp_resp_q;
    rsp_mismatch = rsp_mismatch_q;
    rsp_timeout  = rsp_timeout_q;
    cmd_unused   = cmd_q.write | (|(cmd_q.addr >> ADDR_W)) | (|(cmd_q.data >> DATA_W));
  end
`ifdef CMD_PLAYER_STATS_EN
  logic [15:0] stat_cmd_q, stat_cmd_d, stat_err_q, stat_err_d;
  logic rsp_hs, rsp_err;
  always_comb begin
    rsp_hs         = rsp_valid && rsp_ready;
    rsp_err        = rsp_mismatch_q || rsp_timeout_q || rsp_resp_q != RESP_OKAY;
    stat_cmd_d     = (rsp_hs && stat_cmd_q != 16'hFFFF) ? stat_cmd_q + 16'd1 : stat_cmd_q;
    stat_err_d     = (rsp_hs && rsp_err && stat_err_q != 16'hFFFF) ? stat_err_q + 16'd1 : stat_err_q;
    stat_cmd_count = stat_cmd_q;
    stat_err_count = stat_err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_cmd_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_cmd_q <= stat_cmd_d;
      stat_err_q <= stat_err_d;
    end
`endif
endmodule

// File: tb/tb_axi_lite_cmd_player.sv
// tb_axi_lite_cmd_player: table-driven zero-wait transactions plus stall, timeout, back-to-back and reset sequences.
module tb_axi_lite_cmd_player;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic cmd_ready, rsp_valid, rsp_mismatch, rsp_timeout;
  logic [31:0] rsp_data;
  logic [1:0] rsp_resp;
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [3:0] w_strb;
  logic aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic aw_ready = 0, w_ready = 0, b_valid = 0, ar_ready = 0, r_valid = 0;
  logic [1:0] b_resp = '0, r_resp = '0;
  logic [31:0] r_data = '0;
  int checks = 0, failures = 0;

  axi_lite_cmd_player #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_mismatch(rsp_mismatch), .rsp_timeout(rsp_timeout),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [1:0]  sresp;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic        exp_mism;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    while (!rsp_valid && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic rsp_hs();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic slave(input logic awr, input logic wr, input logic bv, input logic arr, input logic rv);
    aw_ready = awr; w_ready = wr; b_valid = bv; ar_ready = arr; r_valid = rv;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_data = d;
  endtask

  initial begin
    int cyc, n;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         2'b00, 32'h0,         2'b00, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'b00, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'b00, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 32'h0,         2'b10, 32'h0,         2'b10, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0024, 32'hCAFE_0000, 32'hCAFE_0000, 2'b11, 32'hCAFE_0000, 2'b11, 1'b0};
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}, 0);
    chk("rst_payload", {aw_addr, w_data}, 0);
    chk("rst_rsp", {rsp_data, rsp_resp, rsp_mismatch, rsp_timeout}, 0);
    @(negedge clk);
    rst = 0;
    tick();

    for (int i = 0; i < 5; i++) begin
      slave(1, 1, 1, 1, 1);
      b_resp = vecs[i].sresp; r_resp = vecs[i].sresp; r_data = vecs[i].rdata;
      issue(vecs[i].wr, vecs[i].addr, vecs[i].data);
      chk($sformatf("v%0d_cmd_ready", i), cmd_ready, 1);
      tick();
      cmd_valid = 0;
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_aw_w_valid", i), {aw_valid, w_valid, ar_valid}, 3'b110);
        chk($sformatf("v%0d_aw_addr", i), aw_addr, vecs[i].addr);
        chk($sformatf("v%0d_w_data_strb", i), {w_data, w_strb}, {vecs[i].data, 4'hF});
      end else begin
        chk($sformatf("v%0d_ar_valid", i), {aw_valid, w_valid, ar_valid}, 3'b001);
        chk($sformatf("v%0d_ar_addr", i), ar_addr, vecs[i].addr);
      end
      chk($sformatf("v%0d_cmd_ready_busy", i), cmd_ready, 0);
      wait_rsp(1, cyc);
      chk($sformatf("v%0d_latency", i), cyc, 3);
      chk($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
      chk($sformatf("v%0d_rsp_resp", i), rsp_resp, vecs[i].exp_resp);
      chk($sformatf("v%0d_rsp_mism_tmo", i), {rsp_mismatch, rsp_timeout}, {vecs[i].exp_mism, 1'b0});
      rsp_hs();
      chk($sformatf("v%0d_idle_after", i), {rsp_valid, cmd_ready}, 2'b01);
    end

    // w accepted three cycles before aw
    slave(0, 1, 0, 0, 0);
    b_resp = 2'b00;
    issue(1, 32'h0000_0040, 32'h0000_55AA);
    tick();
    cmd_valid = 0;
    chk("wf_c1_valids", {aw_valid, w_valid}, 2'b11);
    n = 0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("wf_c%0d_valids", c), {aw_valid, w_valid, b_ready}, 3'b100);
      chk($sformatf("wf_c%0d_aw_addr", c), aw_addr, 32'h0000_0040);
    end
    aw_ready = 1;
    tick();
    chk("wf_c5_valids", {aw_valid, w_valid, b_ready}, 3'b001);
    for (int c = 0; c < 3; c++) begin
      if (b_ready) n++;
      if (c == 1) b_valid = 1;
      tick();
    end
    chk("wf_b_ready_cycles", n, 2);
    chk("wf_rsp", {rsp_valid, b_ready, rsp_resp, rsp_timeout}, {1'b1, 1'b0, 2'b00, 1'b0});
    rsp_hs();
    chk("wf_b_ready_after", b_ready, 0);

    // ar_ready never rises: timeout after 16 request cycles
    slave(0, 0, 0, 0, 0);
    issue(0, 32'h0000_0080, 32'h0);
    tick();
    cmd_valid = 0;
    n = 0;
    for (int c = 0; c < 40 && !rsp_valid; c++) begin
      if (ar_valid) n++;
      tick();
    end
    chk("tmo_ar_cycles", n, 16);
    chk("tmo_ar_valid", {ar_valid, r_ready, rsp_valid}, 3'b001);
    chk("tmo_rsp", {rsp_timeout, rsp_resp, rsp_mismatch}, {1'b1, 2'b10, 1'b0});
    chk("tmo_rsp_data", rsp_data, 0);
    rsp_hs();

    // rsp back-pressure with a pending command, then back-to-back commands
    slave(1, 1, 1, 1, 1);
    b_resp = 2'b00; r_resp = 2'b00; r_data = 32'h1111_1111;
    issue(0, 32'h0000_0100, 32'h1111_1111);
    tick();
    issue(0, 32'h0000_0104, 32'h2222_2222);
    wait_rsp(1, cyc);
    chk("bp_latency", cyc, 3);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d", c), {cmd_ready, rsp_valid, rsp_data, rsp_mismatch},
          {1'b0, 1'b1, 32'h1111_1111, 1'b0});
      tick();
    end
    rsp_hs();
    chk("b2b_accept1", cmd_ready, 1);
    tick();
    issue(1, 32'h0000_0108, 32'h3333_3333);
    wait_rsp(1, cyc);
    chk("b2b_rsp1", {rsp_data, rsp_mismatch, rsp_timeout}, {32'h1111_1111, 1'b1, 1'b0});
    rsp_hs();
    chk("b2b_accept2", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("b2b_aw_addr", {aw_valid, aw_addr, w_data}, {1'b1, 32'h0000_0108, 32'h3333_3333});
    wait_rsp(1, cyc);
    chk("b2b_rsp2", {cyc[7:0], rsp_data, rsp_resp, rsp_mismatch}, {8'd3, 32'h0, 2'b00, 1'b0});
    rsp_hs();

    // asynchronous reset while waiting for b_valid
    slave(1, 1, 0, 1, 0);
    issue(1, 32'h0000_0200, 32'h4444_4444);
    tick();
    cmd_valid = 0;
    tick();
    chk("rw_b_ready", b_ready, 1);
    #2 rst = 1;
    #1;
    chk("rw_async_valids", {cmd_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid}, 0);
    chk("rw_async_payload", {aw_addr, w_data, rsp_data}, 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("rw_no_rsp", rsp_valid, 0);
    b_valid = 1;
    issue(1, 32'h0000_0204, 32'h7777_7777);
    chk("rw_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("rw_aw_addr", aw_addr, 32'h0000_0204);
    wait_rsp(1, cyc);
    chk("rw_latency", cyc, 3);
    chk("rw_rsp", {rsp_resp, rsp_timeout, rsp_mismatch}, 0);
    rsp_hs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/axi_lite_cmd_player.md
Name: axi_lite_cmd_player

Overview:
- Hardware AXI-Lite master that sits directly upstream of chip_control and drives its axi_port.
- Consumes a stream of write/read-check commands and issues one AXI-Lite transaction per command.
- Returns read data, the response code and a mismatch flag per command.
- Used for on-FPGA bring-up and for replaying test vectors without a CPU.

Parameters:
- ADDR_W, 32, AXI-Lite address width
- DATA_W, 32, AXI-Lite data width; must be a multiple of 8
- TIMEOUT_CYCLES, 1024, number of cycles a handshake may stall before the command is aborted; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle
- cmd_write  in  1  1 = write, 0 = read-check
- cmd_addr  in  ADDR_W  target address
- cmd_data  in  DATA_W  write data, or expected read data
- rsp_valid  out  1  result present
- rsp_ready  in  1  result consumed
- rsp_data  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  b_resp or r_resp (2'b10 on timeout)
- rsp_mismatch  out  1  read data differs from expected (always 0 for writes)
- rsp_timeout  out  1  command aborted by timeout
- aw_addr, aw_valid  out  ADDR_W, 1;  aw_ready  in  1
- w_data, w_valid  out  DATA_W, 1;  w_strb  out  DATA_W/8 (all ones);  w_ready  in  1
- b_resp  in  2;  b_valid  in  1;  b_ready  out  1
- ar_addr, ar_valid  out  ADDR_W, 1;  ar_ready  in  1
- r_data  in  DATA_W;  r_resp  in  2;  r_valid  in  1;  r_ready  out  1

Behaviour:
- Reset (async, rst=1): FSM to IDLE; every valid/ready output 0; all addr/data/rsp_* outputs 0; timer 0.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_* and clear the timer.
  - cmd_write=1 → WR_REQ; cmd_write=0 → RD_REQ.
  - cmd_ready is 0 in every other state.
- WR_REQ: aw_valid and w_valid rise the cycle after acceptance.
  - Each drops independently after its own handshake (valid & ready at a clock edge).
  - Once both have completed → WR_RESP.
- WR_RESP: b_ready=1. On b_valid, capture b_resp → RSP.
- RD_REQ: ar_valid=1 until ar_ready → RD_RESP.
- RD_RESP: r_ready=1. On r_valid, capture r_data and r_resp; rsp_mismatch = (r_data != expected) → RSP.
- RSP: rsp_valid=1, holding all rsp_* stable until rsp_ready → IDLE.
- Minimum latency with zero-wait slave: accept at cycle 0, request at 1, response at 2, rsp_valid at 3.
- Back-to-back: a new command can be accepted the cycle after an rsp handshake.
- AXI rules:
  - A valid, once asserted, is never dropped and its payload never changes before the handshake.
  - Ready signals do not wait on valid.
- Timeout:
  - The timer counts every cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_RESP.
  - At TIMEOUT_CYCLES: drop every outstanding valid/ready, set rsp_timeout=1 and rsp_resp=2'b10, rsp_data=0, rsp_mismatch=0 → RSP.
  - The timer saturates and never wraps.
- Simultaneous aw and w handshake in the same cycle → WR_RESP next cycle.
- b_valid or r_valid arriving in the same cycle as the request handshake is ignored until the response state (the slave must hold valid).
- Reset mid-transaction aborts immediately; no response is produced.

Optional Feature:
- CMD_PLAYER_STATS_EN defined adds outputs:
  - stat_cmd_count[15:0]: completed commands.
  - stat_err_count[15:0]: responses with mismatch, timeout or resp≠0.
  - Both saturate at 16'hFFFF, reset to 0, and increment on the rsp handshake.
- Not defined: the ports and counters are absent.

Decomposition:
- Package axi_lite_cmd_pkg holds:
  - The state enum: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
  - Response codes: RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - A command struct {write, addr, data}.
- One sub-module, axi_lite_cmd_timer: a saturating counter with clear, enable and expired outputs.

Test Plan:
- Write 0x0000_0010 ← 0xDEAD_BEEF, zero-wait slave → aw/w valid at cycle 1, rsp_valid at cycle 3, rsp_resp=0, rsp_mismatch=0.
- Read-check 0x0000_0010, expected 0xDEAD_BEEF, slave returns the same → rsp_data=0xDEAD_BEEF, mismatch=0. Repeat with expected 0x1234_5678 → mismatch=1.
- Slave asserts w_ready 3 cycles before aw_ready → w_valid drops first, aw_valid is held stable, exactly one b_ready phase.
- TIMEOUT_CYCLES=16, ar_ready tied 0 → after 16 cycles ar_valid=0, rsp_timeout=1, rsp_resp=2'b10.
- rsp_ready held 0 for 5 cycles with cmd_valid=1 → cmd_ready stays 0 and rsp_* are stable. Then two back-to-back commands are accepted without a lost response.
- rst pulsed during WR_RESP → all outputs 0 asynchronously; the next write completes normally.
